aes_round_sched: RTL and testbench

- Scheduler for an iterative AES-128 encryption engine.
- The engine is one round datapath (round logic followed by a PIPE_DEPTH-stage pipe register) whose output feeds back to its input.
- This block owns a slot ring of PIPE_DEPTH entries, so up to PIPE_DEPTH independent blocks can be interleaved in the loop.
- Per cycle it drives the datapath mux select, the bubble flag (empty_in), Rcon and the final-round flag, and it reports block completion.

---
 rtl/aes_round_sched.sv | 149 ++++++++++++++
 tb/tb_aes_round_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched.sv
// Slot-ring scheduler for an iterative, interleaved AES-128 round datapath.
// Define AES_SCHED_STATS_EN to add the blk_count / stall_count statistics outputs.

module aes_round_sched #(
    parameter int PIPE_DEPTH = 2,
    parameter int NUM_ROUNDS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        dp_load,
    output logic        dp_empty,
    output logic [7:0]  dp_rcon,
    output logic        dp_final,
    output logic        out_valid,
    output logic        busy
`ifdef AES_SCHED_STATS_EN
    ,
    output logic [15:0] blk_count,
    output logic [15:0] stall_count
`endif
);

    localparam int              SP_W     = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_MAX   = SP_W'(PIPE_DEPTH - 1);
    localparam logic [3:0]      LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ACT_BUBBLE,
        ACT_LOAD,
        ACT_RECIRC
    } act_e;

    logic [SP_W-1:0]       sp_q;
    logic [SP_W-1:0]       sp_d;
    logic [PIPE_DEPTH-1:0] occ_q;
    logic [3:0]            rnd_q  [PIPE_DEPTH];
    logic [7:0]            rcon_q [PIPE_DEPTH];

    logic       cur_occ;
    logic [3:0] cur_rnd;
    logic [7:0] cur_rcon;
    logic       fin;
    act_e       act;
    logic       slot_occ_d;
    logic [3:0] slot_rnd_d;
    logic [7:0] slot_rcon_d;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Only the slot under the pointer is visible; its token is returning from the loop now.
    assign cur_occ  = occ_q[sp_q];
    assign cur_rnd  = rnd_q[sp_q];
    assign cur_rcon = rcon_q[sp_q];
    assign fin      = cur_occ && (cur_rnd == LAST_RND);
    assign sp_d     = (sp_q == SP_MAX) ? '0 : sp_q + 1'b1;

    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
        in_ready    = 1'b0;
        dp_load     = 1'b0;
        dp_empty    = 1'b1;
        dp_rcon     = 8'h00;
        dp_final    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        act         = ACT_BUBBLE;
        slot_occ_d  = cur_occ;
        slot_rnd_d  = cur_rnd;
        slot_rcon_d = cur_rcon;

        if (!reset) begin
            out_valid = fin;
            busy      = |occ_q;
            in_ready  = !cur_occ || fin;

            if (cur_occ && !fin) begin
                act = ACT_RECIRC;
            end else if (in_valid && in_ready) begin
                act = ACT_LOAD;
            end

            unique case (act)
                ACT_RECIRC: begin
                    dp_empty    = 1'b0;
                    dp_rcon     = xtime(cur_rcon);
                    dp_final    = (cur_rnd + 4'd1 == LAST_RND);
                    slot_rnd_d  = cur_rnd + 4'd1;
                    slot_rcon_d = xtime(cur_rcon);
                end
                ACT_LOAD: begin
                    dp_load     = 1'b1;
                    dp_empty    = 1'b0;
                    dp_rcon     = 8'h01;
                    dp_final    = (NUM_ROUNDS == 1);
                    slot_occ_d  = 1'b1;
                    slot_rnd_d  = 4'd1;
                    slot_rcon_d = 8'h01;
                end
                default: begin
                    slot_occ_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the slot arrays are a handful of flops, not a RAM, so they take the reset too.
            sp_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                rnd_q[i]  <= 4'd0;
                rcon_q[i] <= 8'h00;
            end
        end else begin
            sp_q         <= sp_d;
            occ_q[sp_q]  <= slot_occ_d;
            rnd_q[sp_q]  <= slot_rnd_d;
            rcon_q[sp_q] <= slot_rcon_d;
        end
    end

`ifdef AES_SCHED_STATS_EN
    logic [15:0] blk_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            blk_cnt_q   <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            if (out_valid) begin
                blk_cnt_q <= blk_cnt_q + 16'h0001;
            end
            if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'h0001;
            end
        end
    end

    assign blk_count   = blk_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched with PIPE_DEPTH=2, NUM_ROUNDS=10 and a behavioural
// AES-128 round datapath closing the loop for an end-to-end FIPS-197 check.

module tb_aes_round_sched;

    localparam int PD = 2;
    localparam int NR = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       dp_load;
    logic       dp_empty;
    logic [7:0] dp_rcon;
    logic       dp_final;
    logic       out_valid;
    logic       busy;
`ifdef AES_SCHED_STATS_EN
    logic [15:0] blk_count;
    logic [15:0] stall_count;
`endif

    aes_round_sched #(
        .PIPE_DEPTH(PD),
        .NUM_ROUNDS(NR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dp_load    (dp_load),
        .dp_empty   (dp_empty),
        .dp_rcon    (dp_rcon),
        .dp_final   (dp_final),
        .out_valid  (out_valid),
        .busy       (busy)
`ifdef AES_SCHED_STATS_EN
        ,
        .blk_count  (blk_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT just out of reset at the start of cycle 0 (slot pointer 0).
    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- behavioural AES-128 round datapath ----------------
    logic [7:0]   sbox_tab [256];
    logic [127:0] pt_in  = '0;
    logic [127:0] key_in = '0;
    logic [127:0] st_pipe  [PD];
    logic [127:0] key_pipe [PD];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    initial begin
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            logic [7:0] a;
            a   = 8'(v);
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, a);
            if (v == 0) inv = 8'h00;
            sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w4, w5, w6, w7, t;
        t  = {sbox_tab[k[23:16]], sbox_tab[k[15:8]], sbox_tab[k[7:0]], sbox_tab[k[31:24]]}
             ^ {rc, 24'h000000};
        w4 = k[127:96] ^ t;
        w5 = k[95:64] ^ w4;
        w6 = k[63:32] ^ w5;
        w7 = k[31:0] ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic [7:0] rc, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox_tab[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) b[4*c+rr] = a[4*((c+rr)%4)+rr];
        for (int c = 0; c < 4; c++) begin
            x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
            if (last) begin
                r[127-32*c -: 32] = {x0, x1, x2, x3};
            end else begin
                r[127-32*c -: 32] = {xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3,
                                     x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3,
                                     x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3,
                                     xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3)};
            end
        end
        return r ^ key_next(k, rc);
    endfunction

    always @(posedge clock) begin
        st_pipe[0]  <= aes_round(dp_load ? (pt_in ^ key_in) : st_pipe[PD-1],
                                 dp_load ? key_in : key_pipe[PD-1], dp_rcon, dp_final);
        key_pipe[0] <= key_next(dp_load ? key_in : key_pipe[PD-1], dp_rcon);
        for (int i = 1; i < PD; i++) begin
            st_pipe[i]  <= st_pipe[i-1];
            key_pipe[i] <= key_pipe[i-1];
        end
    end

    // ---------------- single-block vector table ----------------
    typedef struct {
        logic       vin;
        logic       ready;
        logic       load;
        logic       empty;
        logic [7:0] rcon;
        logic       fin;
        logic       ov;
        logic       busy;
    } vec_t;

    vec_t vecs [22];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            vin ready load empty rcon  fin ov busy
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h1B, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h36, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

        // Outputs while reset is held.
        in_valid = 1'b1;
        next_cycle();
        @(negedge clock);
        check("rst in_ready",  128'(in_ready),  128'(0));
        check("rst dp_load",   128'(dp_load),   128'(0));
        check("rst dp_empty",  128'(dp_empty),  128'(1));
        check("rst dp_rcon",   128'(dp_rcon),   128'(0));
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst busy",      128'(busy),      128'(0));

        // Single block, full round sequence.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            in_valid = vecs[c].vin;
            @(negedge clock);
            check($sformatf("t1 c%0d in_ready", c),  128'(in_ready),  128'(vecs[c].ready));
            check($sformatf("t1 c%0d dp_load", c),   128'(dp_load),   128'(vecs[c].load));
            check($sformatf("t1 c%0d dp_empty", c),  128'(dp_empty),  128'(vecs[c].empty));
            check($sformatf("t1 c%0d dp_rcon", c),   128'(dp_rcon),   128'(vecs[c].rcon));
            check($sformatf("t1 c%0d dp_final", c),  128'(dp_final),  128'(vecs[c].fin));
            check($sformatf("t1 c%0d out_valid", c), 128'(out_valid), 128'(vecs[c].ov));
            check($sformatf("t1 c%0d busy", c),      128'(busy),      128'(vecs[c].busy));
            next_cycle();
        end

        // Back-to-back loads with retire-and-reload on slot 0 at cycle 20.
        do_reset();
        for (int c = 0; c < 43; c++) begin
            in_valid = (c <= 20);
            @(negedge clock);
            if (c <= 20)
                check($sformatf("t2 c%0d in_ready", c), 128'(in_ready), 128'((c <= 1) || (c == 20)));
            if (c == 20)
                check("t2 c20 dp_load", 128'(dp_load), 128'(1));
            check($sformatf("t2 c%0d out_valid", c), 128'(out_valid),
                  128'((c == 20) || (c == 21) || (c == 40)));
            next_cycle();
        end
`ifdef AES_SCHED_STATS_EN
        @(negedge clock);
        check("stats blk_count",   128'(blk_count),   128'(3));
        check("stats stall_count", 128'(stall_count), 128'(18));
        do_reset();
        @(negedge clock);
        check("stats blk_count after reset",   128'(blk_count),   128'(0));
        check("stats stall_count after reset", 128'(stall_count), 128'(0));
        next_cycle();
`endif

        // Single block on slot 1: even cycles are bubbles.
        do_reset();
        for (int c = 0; c < 24; c++) begin
            in_valid = (c == 1);
            @(negedge clock);
            if (c <= 20)
                check($sformatf("t3 c%0d dp_empty", c), 128'(dp_empty), 128'(c % 2 == 0));
            check($sformatf("t3 c%0d out_valid", c), 128'(out_valid), 128'(c == 21));
            next_cycle();
        end

        // Reset mid-operation discards in-flight blocks.
        do_reset();
        for (int c = 0; c < 36; c++) begin
            reset    = (c == 9);
            in_valid = (c <= 1) || (c == 9) || (c == 12);
            @(negedge clock);
            if (c == 8) check("t4 c8 busy", 128'(busy), 128'(1));
            if (c == 9) begin
                check("t4 c9 in_ready", 128'(in_ready), 128'(0));
                check("t4 c9 dp_load",  128'(dp_load),  128'(0));
                check("t4 c9 dp_empty", 128'(dp_empty), 128'(1));
                check("t4 c9 dp_rcon",  128'(dp_rcon),  128'(0));
                check("t4 c9 dp_final", 128'(dp_final), 128'(0));
            end
            if (c == 10 || c == 11)
                check($sformatf("t4 c%0d busy", c), 128'(busy), 128'(0));
            check($sformatf("t4 c%0d out_valid", c), 128'(out_valid), 128'(c == 32));
            next_cycle();
        end

        // End-to-end FIPS-197 vector through the behavioural datapath.
        do_reset();
        key_in   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pt_in    = 128'h3243f6a8885a308d313198a2e0370734;
        in_valid = 1'b1;
        begin
            int seen_at;
            seen_at = -1;
            for (int c = 0; c < 100 && seen_at < 0; c++) begin
                @(negedge clock);
                if (out_valid) begin
                    seen_at = c;
                    check("t5 ciphertext", st_pipe[PD-1], 128'h3925841d02dc09fbdc118597196a0b32);
                    check("t5 latency", 128'(seen_at), 128'(NR * PD));
                end
                next_cycle();
                in_valid = 1'b0;
            end
            if (seen_at < 0) check("t5 out_valid timeout", 128'(0), 128'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
